// File: rtl/ceespu_cache_pkg.sv
// Shared geometry, tag layout and refill state encoding for the ceespu
// instruction cache and its line-refill engine.
package ceespu_cache_pkg;

  localparam int ADDR_BITS       = 25;
  localparam int OFFSET_BITS     = 6;
  localparam int SET_BITS        = 7;
  localparam int TAG_BITS        = ADDR_BITS - SET_BITS - OFFSET_BITS;
  localparam int WORDS_PER_LINE  = 1 << OFFSET_BITS;

  // SDRAM burst geometry: power of two, no longer than a line.
  localparam int BURST_LEN       = 8;
  localparam int BURSTS_PER_LINE = WORDS_PER_LINE / BURST_LEN;
  localparam int BURST_CNT_BITS  = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;

  // Tag RAM entry layout.
  localparam int TAG_ENTRY_BITS  = 16;
  localparam int VALID_BIT       = 15;
  localparam int USED_BIT        = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INVAL = 3'd1,
    REQ   = 3'd2,
    DATA  = 3'd3,
    TAG   = 3'd4,
    DONE  = 3'd5
  } refill_state_e;

  // Build a tag RAM entry {valid, used, zeros, tag}.
  function automatic logic [TAG_ENTRY_BITS-1:0] make_tag_entry(
    input logic                valid,
    input logic                used,
    input logic [TAG_BITS-1:0] tag
  );
    logic [TAG_ENTRY_BITS-1:0] entry;
    entry                = {TAG_ENTRY_BITS{1'b0}};
    entry[VALID_BIT]     = valid;
    entry[USED_BIT]      = used;
    entry[TAG_BITS-1:0]  = tag;
    return entry;
  endfunction

endpackage

// File: rtl/ceespu_icache_refill_if.sv
// Bundle of the icache miss handshake, the SDRAM read port and the cache
// RAM write ports seen by the refill engine. The refill engine is the slave.
interface ceespu_icache_refill_if;
  import ceespu_cache_pkg::*;

  // icache miss handshake
  logic                      miss_req;
  logic [ADDR_BITS-1:0]      miss_addr;
  logic                      miss_way;
  logic                      busy;
  logic                      miss_done;
  // SDRAM controller read port
  logic                      sdram_req;
  logic [ADDR_BITS-1:0]      sdram_addr;
  logic                      sdram_ack;
  logic                      sdram_rvalid;
  logic [31:0]               sdram_rdata;
  // data BRAM and tag RAM write ports
  logic [15:0]               bramaddress;
  logic [31:0]               bramdata;
  logic                      bramwe;
  logic [9:0]                tagramaddr;
  logic [TAG_ENTRY_BITS-1:0] tagdata;
  logic                      tagwe;
  // critical-word forwarding
  logic                      crit_valid;
  logic [31:0]               crit_data;

  modport slave (
    input  miss_req, miss_addr, miss_way, sdram_ack, sdram_rvalid, sdram_rdata,
    output busy, miss_done, sdram_req, sdram_addr, bramaddress, bramdata, bramwe,
           tagramaddr, tagdata, tagwe, crit_valid, crit_data
  );

  modport master (
    output miss_req, miss_addr, miss_way, sdram_ack, sdram_rvalid, sdram_rdata,
    input  busy, miss_done, sdram_req, sdram_addr, bramaddress, bramdata, bramwe,
           tagramaddr, tagdata, tagwe, crit_valid, crit_data
  );

endinterface

// File: rtl/ceespu_refill_addrgen.sv
// Word offset and burst counters for a line refill.
// Optional macro CEESPU_REFILL_CRITICAL_FIRST_EN: start the fill at the burst
// holding the missed word, wrap around the line, and flag the missed word.
module ceespu_refill_addrgen
  import ceespu_cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OFFSET_BITS-1:0] miss_offset,
  input  logic                   word_we,
  output logic [OFFSET_BITS-1:0] offset,
  output logic                   burst_last,
  output logic                   line_last,
  output logic                   crit_hit
);

  localparam logic [OFFSET_BITS-1:0] BURST_MASK = OFFSET_BITS'(BURST_LEN - 1);

  logic [OFFSET_BITS-1:0]    offset_r;
  logic [BURST_CNT_BITS-1:0] burst_cnt_r;
  logic [OFFSET_BITS-1:0]    start_offset_s;

`ifdef CEESPU_REFILL_CRITICAL_FIRST_EN
  logic [OFFSET_BITS-1:0] crit_offset_r;

  assign start_offset_s = miss_offset & ~BURST_MASK;

  // Remember which word the icache is stalled on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crit_offset_r <= '0;
    end else if (start) begin
      crit_offset_r <= miss_offset;
    end
  end

  assign crit_hit = word_we && (offset_r == crit_offset_r);
`else
  logic unused_miss_offset_s;

  assign unused_miss_offset_s = ^miss_offset;
  assign start_offset_s       = '0;
  assign crit_hit             = 1'b0;
`endif

  // Bursts are aligned, so the low offset bits count words within a burst.
  assign burst_last = ((offset_r & BURST_MASK) == BURST_MASK);
  assign line_last  = burst_last &&
                      (burst_cnt_r == BURST_CNT_BITS'(BURSTS_PER_LINE - 1));
  assign offset     = offset_r;

  // Advance the offset per written word (wrapping in the line) and count bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_r    <= '0;
      burst_cnt_r <= '0;
    end else if (start) begin
      offset_r    <= start_offset_s;
      burst_cnt_r <= '0;
    end else if (word_we) begin
      offset_r <= offset_r + OFFSET_BITS'(1);
      if (burst_last) begin
        burst_cnt_r <= burst_cnt_r + BURST_CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/ceespu_icache_refill.sv
// ceespu icache line refill: invalidates the victim tag, streams the line in
// from SDRAM as bursts into the data BRAM, then writes the valid tag.
// Optional macro CEESPU_REFILL_CRITICAL_FIRST_EN (see ceespu_refill_addrgen).
module ceespu_icache_refill
  import ceespu_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ceespu_icache_refill_if.slave bus
);

  refill_state_e state_r, state_next_s;

  logic [TAG_BITS-1:0]       tag_r;
  logic [SET_BITS-1:0]       set_r;
  logic                      way_r;
  logic [15:0]               bram_addr_r;
  logic [31:0]               bram_data_r;
  logic [9:0]                tag_addr_r;

  logic                      start_s;
  logic                      word_we_s;
  logic                      burst_last_s;
  logic                      line_last_s;
  logic                      crit_hit_s;
  logic [OFFSET_BITS-1:0]    offset_s;
  logic [15:0]               bram_addr_s;
  logic [9:0]                tag_addr_s;
  logic                      busy_s;
  logic                      done_s;
  logic                      sdram_req_s;
  logic                      tag_we_s;
  logic [TAG_ENTRY_BITS-1:0] tag_data_s;

  assign start_s     = (state_r == IDLE) && bus.miss_req;
  assign word_we_s   = (state_r == DATA) && bus.sdram_rvalid;
  assign bram_addr_s = {{(16 - 1 - SET_BITS - OFFSET_BITS){1'b0}}, way_r, set_r, offset_s};
  assign tag_addr_s  = {{(10 - 1 - SET_BITS){1'b0}}, way_r, set_r};

  ceespu_refill_addrgen u_addrgen (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
    .miss_offset (bus.miss_addr[OFFSET_BITS-1:0]),
    .word_we     (word_we_s),
    .offset      (offset_s),
    .burst_last  (burst_last_s),
    .line_last   (line_last_s),
    .crit_hit    (crit_hit_s)
  );

  // Capture tag, set and victim way when a miss is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r <= '0;
      set_r <= '0;
      way_r <= 1'b0;
    end else if (start_s) begin
      tag_r <= bus.miss_addr[ADDR_BITS-1 -: TAG_BITS];
      set_r <= bus.miss_addr[OFFSET_BITS +: SET_BITS];
      way_r <= bus.miss_way;
    end
  end

  // Refill state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: one burst per REQ/DATA round trip until the line is full.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.miss_req) state_next_s = INVAL;
        else              state_next_s = IDLE;
      end
      INVAL: state_next_s = REQ;
      REQ: begin
        if (bus.sdram_ack) state_next_s = DATA;
        else               state_next_s = REQ;
      end
      DATA: begin
        if (word_we_s && line_last_s)       state_next_s = TAG;
        else if (word_we_s && burst_last_s) state_next_s = REQ;
        else                                state_next_s = DATA;
      end
      TAG:     state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Decode the state into handshake strobes and the tag RAM write.
  always_comb begin
    busy_s      = 1'b1;
    done_s      = 1'b0;
    sdram_req_s = 1'b0;
    tag_we_s    = 1'b0;
    tag_data_s  = {TAG_ENTRY_BITS{1'b0}};
    case (state_r)
      IDLE:  busy_s      = 1'b0;
      INVAL: tag_we_s    = 1'b1;
      REQ:   sdram_req_s = 1'b1;
      DATA:  busy_s      = 1'b1;
      TAG: begin
        tag_we_s   = 1'b1;
        tag_data_s = make_tag_entry(1'b1, 1'b0, tag_r);
      end
      DONE:    done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Hold the last RAM addresses and data so the ports stay quiet between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_addr_r <= '0;
      bram_data_r <= '0;
      tag_addr_r  <= '0;
    end else begin
      if (word_we_s) begin
        bram_addr_r <= bram_addr_s;
        bram_data_r <= bus.sdram_rdata;
      end
      if (tag_we_s) begin
        tag_addr_r <= tag_addr_s;
      end
    end
  end

  assign bus.busy        = busy_s;
  assign bus.miss_done   = done_s;
  assign bus.sdram_req   = sdram_req_s;
  assign bus.sdram_addr  = sdram_req_s ? {tag_r, set_r, offset_s} : '0;
  assign bus.bramwe      = word_we_s;
  assign bus.bramaddress = word_we_s ? bram_addr_s : bram_addr_r;
  assign bus.bramdata    = word_we_s ? bus.sdram_rdata : bram_data_r;
  assign bus.tagwe       = tag_we_s;
  assign bus.tagramaddr  = tag_we_s ? tag_addr_s : tag_addr_r;
  assign bus.tagdata     = tag_data_s;
  assign bus.crit_valid  = crit_hit_s;
  assign bus.crit_data   = crit_hit_s ? bus.sdram_rdata : 32'h0000_0000;

endmodule
